// File: rtl/candidate_engine_pkg.sv
// rtl/candidate_engine_pkg.sv - shared types, widths and helpers for candidate_engine
// Purpose: set-relation mode encodings, field widths, scan length and the
//          per-point mode resolution function.
// Ports:   none (package).
package candidate_engine_pkg;

   typedef enum logic [1:0] {
      MODE_A   = 2'b00,
      MODE_AND = 2'b01,
      MODE_XOR = 2'b10,
      MODE_TWO = 2'b11
   } mode_e;

   localparam int COORD_W  = 4;
   localparam int CNT_W    = 8;
   localparam int SCAN_LEN = 16;

   // Combine the three circle hits for one grid point; only MODE_TWO looks at C.
   function automatic logic resolve(input mode_e m, input logic a, input logic b, input logic c);
      logic r;
      case (m)
         MODE_A:   r = a;
         MODE_AND: r = a & b;
         MODE_XOR: r = a ^ b;
         default:  r = (a & b & ~c) | (a & ~b & c) | (~a & b & c);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/candidate_engine_if.sv
// rtl/candidate_engine_if.sv - controller-to-engine strobe and result bundle
// Purpose: groups the controller strobes, job descriptors and the count result.
// Ports:   buffer_en_i, central_i[23:0], radius_i[11:0], mode_i[1:0],
//          coord_en_i, acc_clear_i, acc_en_i (controller -> engine);
//          candidate_o[7:0] (engine -> controller).
interface candidate_engine_if;
   import candidate_engine_pkg::*;

   logic                 buffer_en_i;
   logic [6*COORD_W-1:0] central_i;
   logic [3*COORD_W-1:0] radius_i;
   logic [1:0]           mode_i;
   logic                 coord_en_i;
   logic                 acc_clear_i;
   logic                 acc_en_i;
   logic [CNT_W-1:0]     candidate_o;

   modport master (
      output buffer_en_i, central_i, radius_i, mode_i,
      output coord_en_i, acc_clear_i, acc_en_i,
      input  candidate_o
   );

   modport slave (
      input  buffer_en_i, central_i, radius_i, mode_i,
      input  coord_en_i, acc_clear_i, acc_en_i,
      output candidate_o
   );
endinterface

// File: rtl/candidate_engine_circle_hit.sv
// rtl/candidate_engine_circle_hit.sv - combinational point-in-circle test
// Purpose: hit = (x-xc)^2 + (y-yc)^2 <= r^2 for one point and one circle.
// Ports:   x, y (point), xc, yc (centre), r (radius), all 4 bits; hit (out).
module circle_hit
   import candidate_engine_pkg::*;
(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] xc,
   input  logic [COORD_W-1:0] yc,
   input  logic [COORD_W-1:0] r,
   output logic               hit
);

   logic [4:0] dx, dy, adx, ady;
   logic [9:0] dx_sq_full, dy_sq_full;
   logic [5:0] dx_sq, dy_sq;
   logic [6:0] sum;
   logic [7:0] r_sq;

   // 5-bit two's complement differences, folded to magnitude before squaring.
   assign dx  = {1'b0, x} - {1'b0, xc};
   assign dy  = {1'b0, y} - {1'b0, yc};
   assign adx = dx[4] ? (5'd0 - dx) : dx;
   assign ady = dy[4] ? (5'd0 - dy) : dy;

   assign dx_sq_full = {5'd0, adx} * {5'd0, adx};
   assign dy_sq_full = {5'd0, ady} * {5'd0, ady};

   // In-grid centres keep |d| <= 7, so each square fits in 6 bits.
   assign dx_sq = dx_sq_full[5:0];
   assign dy_sq = dy_sq_full[5:0];
   assign sum   = {1'b0, dx_sq} + {1'b0, dy_sq};
   assign r_sq  = {4'd0, r} * {4'd0, r};

   assign hit = ({1'b0, sum} <= r_sq);

endmodule

// File: rtl/candidate_engine.sv
// rtl/candidate_engine.sv - grid scan engine counting points in a circle set relation
// Purpose: latches three circles and a mode, scans the GRIDxGRID grid LANES
//          points per issue through a two-stage pipeline, accumulates hits.
// Ports:   clk_i, rst_ni (async active-low); bus (candidate_engine_if.slave):
//          capture/scan/clear strobes in, candidate_o count out.
module candidate_engine
   import candidate_engine_pkg::*;
#(
   parameter int GRID  = 8,
   parameter int LANES = 4
)
(
   input  logic               clk_i,
   input  logic               rst_ni,
   candidate_engine_if.slave  bus
);

   localparam int         ROW_ISSUES = GRID / LANES;
   localparam logic [4:0] IDX_END    = 5'(SCAN_LEN);

   logic [6*COORD_W-1:0] central_q;
   logic [3*COORD_W-1:0] radius_q;
   mode_e                mode_q;
   logic [4:0]           idx;
   logic                 s1_valid;
   logic [LANES-1:0]     s1_hits;
   logic [CNT_W-1:0]     cnt;

   logic                 idle;
   logic                 issue;
   logic [COORD_W-1:0]   py;
   logic [COORD_W-1:0]   col_sel;
   logic [LANES-1:0]     lane_hit;
   logic [CNT_W-1:0]     pop;
   logic [COORD_W-1:0]   cx [3];
   logic [COORD_W-1:0]   cy [3];
   logic [COORD_W-1:0]   cr [3];

   assign idle  = (idx == IDX_END) && !s1_valid;
   // A restart in the same cycle wins over an issue.
   assign issue = bus.acc_en_i && (idx < IDX_END) && !bus.coord_en_i;

   // Each row takes ROW_ISSUES issues; idx selects row and column block.
   assign py      = 4'(idx / 5'(ROW_ISSUES)) + 4'd1;
   assign col_sel = 4'(idx % 5'(ROW_ISSUES));

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         cx[c] = central_q[(5-2*c)*COORD_W +: COORD_W];
         cy[c] = central_q[(4-2*c)*COORD_W +: COORD_W];
         cr[c] = radius_q[(2-c)*COORD_W +: COORD_W];
      end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [COORD_W-1:0] px;
      logic [2:0]         h;
      assign px = col_sel * 4'(LANES) + 4'(j + 1);
      for (genvar c = 0; c < 3; c++) begin : g_circle
         circle_hit u_hit (
            .x   (px),
            .y   (py),
            .xc  (cx[c]),
            .yc  (cy[c]),
            .r   (cr[c]),
            .hit (h[c])
         );
      end
      assign lane_hit[j] = resolve(mode_q, h[0], h[1], h[2]);
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + CNT_W'(s1_hits[i]);
      end
   end

   // Descriptor capture is locked out while a scan or drain is in progress.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         central_q <= '0;
         radius_q  <= '0;
         mode_q    <= MODE_A;
      end else if (bus.buffer_en_i && idle) begin
         central_q <= bus.central_i;
         radius_q  <= bus.radius_i;
         mode_q    <= mode_e'(bus.mode_i);
      end
   end

   // Stage 1: scan index and registered mode-resolved hits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx      <= IDX_END;
         s1_valid <= 1'b0;
         s1_hits  <= '0;
      end else if (bus.coord_en_i) begin
         idx      <= '0;
         s1_valid <= 1'b0;
      end else if (issue) begin
         idx      <= idx + 5'd1;
         s1_valid <= 1'b1;
         s1_hits  <= lane_hit;
      end else begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: accumulate regardless of acc_en_i so a paused scan still drains.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= '0;
      end else if (bus.acc_clear_i) begin
         cnt <= '0;
      end else if (s1_valid) begin
         cnt <= cnt + pop;
      end
   end

   assign bus.candidate_o = cnt;

endmodule

// File: tb/tb_candidate_engine.sv
// tb/tb_candidate_engine.sv - scoreboard bench for candidate_engine
module tb_candidate_engine;

   typedef struct {
      logic [7:0] cnt;
      logic [4:0] idx;
      string      name;
   } exp_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic present = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   candidate_engine_if ce ();

   candidate_engine #(.GRID(8), .LANES(4)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (ce)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_now(input string name, input logic [7:0] cnt);
      exp_t e;
      e.cnt  = cnt;
      e.idx  = 5'd16;
      e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: compares whenever the bench marks the output as presented.
   always @(negedge clk_i) begin
      if (present) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: output presented with no expectation queued");
         end else begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (ce.candidate_o !== e.cnt) begin
               n_fail++;
               $display("FAIL %s candidate_o: got %0d expected %0d", e.name, ce.candidate_o, e.cnt);
            end
            n_checks++;
            if (dut.idx !== e.idx) begin
               n_fail++;
               $display("FAIL %s idx: got %0d expected %0d", e.name, dut.idx, e.idx);
            end
         end
      end
   end

   // Acts as the controller: capture, START, 17 BUSY cycles, 2 DONE cycles.
   task automatic run_job(input string name, input logic [23:0] c, input logic [11:0] r,
                          input logic [1:0] m, input logic [7:0] exp_cnt,
                          input logic [7:0] hold_cnt, input bit glitch, input int rst_at);
      ce.buffer_en_i = 1'b1;
      ce.central_i   = c;
      ce.radius_i    = r;
      ce.mode_i      = m;
      expect_now({name, "_hold"}, hold_cnt);
      present = 1'b1;
      step();
      present = 1'b0;
      ce.buffer_en_i = 1'b0;
      ce.coord_en_i  = 1'b1;
      ce.acc_clear_i = 1'b1;
      step();
      ce.coord_en_i  = 1'b0;
      ce.acc_clear_i = 1'b0;
      ce.acc_en_i    = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         if (glitch && i == 5) begin
            ce.buffer_en_i = 1'b1;
            ce.central_i   = 24'h44_0000;
            ce.radius_i    = 12'hF00;
            ce.mode_i      = 2'b00;
         end else begin
            ce.buffer_en_i = 1'b0;
         end
         if (i == rst_at) begin
            rst_ni = 1'b0;
            ce.acc_en_i = 1'b0;
            expect_now({name, "_rst"}, 8'd0);
            present = 1'b1;
            step();
            present = 1'b0;
            rst_ni = 1'b1;
            step();
            return;
         end
         step();
      end
      ce.acc_en_i = 1'b0;
      expect_now({name, "_done1"}, exp_cnt);
      expect_now({name, "_done2"}, exp_cnt);
      present = 1'b1;
      step();
      step();
      present = 1'b0;
   endtask

   initial begin
      ce.buffer_en_i = 1'b0;
      ce.central_i   = '0;
      ce.radius_i    = '0;
      ce.mode_i      = '0;
      ce.coord_en_i  = 1'b0;
      ce.acc_clear_i = 1'b0;
      ce.acc_en_i    = 1'b0;
      step();
      expect_now("reset", 8'd0);
      present = 1'b1;
      step();
      present = 1'b0;
      rst_ni = 1'b1;
      step();

      run_job("a44_r2",   24'h44_0000, 12'h200, 2'b00, 8'd13, 8'd0,  1'b0, 0);
      run_job("a44_r0",   24'h44_0000, 12'h000, 2'b00, 8'd1,  8'd13, 1'b0, 0);
      run_job("a44_r15",  24'h44_0000, 12'hF00, 2'b00, 8'd64, 8'd1,  1'b0, 0);
      run_job("corner",   24'h11_0000, 12'h200, 2'b00, 8'd6,  8'd64, 1'b0, 0);
      run_job("and",      24'h33_5300, 12'h220, 2'b01, 8'd5,  8'd6,  1'b0, 0);
      run_job("xor",      24'h33_5300, 12'h220, 2'b10, 8'd16, 8'd5,  1'b0, 0);
      run_job("two",      24'h33_5388, 12'h220, 2'b11, 8'd5,  8'd16, 1'b0, 0);
      run_job("midrst",   24'h44_0000, 12'h200, 2'b00, 8'd0,  8'd5,  1'b0, 8);
      run_job("post_rst", 24'h44_0000, 12'h200, 2'b00, 8'd13, 8'd0,  1'b0, 0);
      run_job("b2b_job2", 24'h11_0000, 12'h200, 2'b00, 8'd6,  8'd13, 1'b1, 0);

      step();
      step();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
